mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//   Main control unit for the multicycle MIPS datapath; the producer of the ALUOp[1:0] code consumed by ALU control.
//   Moore FSM stepping each instruction through fetch/decode/execute/memory/writeback. Drives every datapath
//   mux select and write enable from the current state. Supported: R-type, lw, sw, beq, j, addi.
// PARAMETERS
//   OP_W     6      opcode field width (instr[31:26])
//   STATE_W  4      state register width (>= 13 states)
// PORTS
//   clk          in   1  single clock, all state updates on posedge
//   reset        in   1  asynchronous, active-high; forces S_RESET
//   opcode       in   6  instr[31:26] from instruction register (valid from S_DECODE onward)
//   mem_ready    in   1  memory handshake; exists only with MIPS_MEM_WAIT_EN
//   PCWrite      out  1  unconditional PC load
//   PCWriteCond  out  1  PC load qualified externally by ALU Zero (beq)
//   IorD         out  1  memory address: 0=PC, 1=ALUOut
//   MemRead      out  1  memory read strobe
//   MemWrite     out  1  memory write strobe
//   IRWrite      out  1  instruction register load
//   MemtoReg     out  1  register write data: 0=ALUOut, 1=MDR
//   RegDst       out  1  write register: 0=rt, 1=rd
//   RegWrite     out  1  register file write enable
//   ALUSrcA      out  1  0=PC, 1=A
//   ALUSrcB      out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
//   ALUOp        out  2  00=add, 01=sub, 10=use funct
//   PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op   out  1  one-cycle pulse in S_DECODE on unsupported opcode
// BEHAVIOUR
//   - Outputs are pure decode of registered state (Moore); no input-to-output combinational path.
//   - Reset: state=S_RESET; all outputs 0 while reset asserted and in S_RESET. S_RESET -> S_FETCH next cycle.
//   - Unlisted outputs in each state are 0. Per state:
//     S_FETCH:   MemRead,IRWrite,PCWrite=1; ALUSrcA=0,ALUSrcB=01,ALUOp=00,PCSource=00,IorD=0 -> S_DECODE
//     S_DECODE:  ALUSrcA=0,ALUSrcB=11,ALUOp=00 (branch target to ALUOut). Next by opcode:
//                lw/sw->S_MEMADR, R(000000)->S_REXEC, beq->S_BEQ, j->S_JUMP, addi->S_ADDIEX, else ->S_FETCH+illegal_op
//     S_MEMADR:  ALUSrcA=1,ALUSrcB=10,ALUOp=00 -> S_MEMRD (lw) / S_MEMWR (sw)
//     S_MEMRD:   MemRead=1,IorD=1 -> S_MEMWB
//     S_MEMWB:   RegWrite=1,MemtoReg=1,RegDst=0 -> S_FETCH
//     S_MEMWR:   MemWrite=1,IorD=1 -> S_FETCH
//     S_REXEC:   ALUSrcA=1,ALUSrcB=00,ALUOp=10 -> S_RWB
//     S_RWB:     RegWrite=1,RegDst=1,MemtoReg=0 -> S_FETCH
//     S_BEQ:     ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCWriteCond=1,PCSource=01 -> S_FETCH
//     S_JUMP:    PCWrite=1,PCSource=10 -> S_FETCH
//     S_ADDIEX:  ALUSrcA=1,ALUSrcB=10,ALUOp=00 -> S_ADDIWB
//     S_ADDIWB:  RegWrite=1,RegDst=0,MemtoReg=0 -> S_FETCH
//   - CPI: lw 5, sw/R/addi 4, beq/j 3. Illegal opcode costs 2 cycles, no architectural write.
//   - Unreachable state encodings -> S_FETCH next cycle, all outputs 0 while there.
//   - reset mid-instruction: immediate abort, no write enables asserted after reset edge.
// CONFIGURATION
//   MIPS_MEM_WAIT_EN defined: mem_ready port present; S_FETCH, S_MEMRD, S_MEMWR hold (outputs held stable,
//     PCWrite/IRWrite/RegWrite not repeated: PCWrite and IRWrite asserted only in the cycle mem_ready=1)
//     until mem_ready=1, then advance. Undefined: no port, memory assumed single-cycle, no stalls.
// STRUCTURE
//   mips_pkg: opcode constants (OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02,
//     OP_ADDI=6'h08), ALUOp codes (ALUOP_ADD/SUB/FUNCT), ALUSrcB/PCSource codes, state encodings.
//   Sub-module mips_ctrl_decode: combinational state -> control-word decoder; top holds state reg + next-state.
// TESTING
//   - reset held 3 cycles, release -> 1 cycle S_RESET all-zero, then FETCH: MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
//   - opcode=6'h23 (lw) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 & MemtoReg=1 only in cycle 5.
//   - opcode=6'h00 -> ALUOp=10 exactly in REXEC; RegDst=1,RegWrite=1 in RWB; back in FETCH on cycle 5.
//   - opcode=6'h04 -> ALUOp=01,PCWriteCond=1,PCSource=01 in cycle 3; opcode=6'h02 -> PCWrite=1,PCSource=10 cycle 3.
//   - opcode=6'h3F -> illegal_op=1 one cycle in DECODE, no RegWrite/MemWrite, FETCH next cycle.
//   - MIPS_MEM_WAIT_EN, sw with mem_ready low 4 cycles in MEMWR -> MemWrite held 5 cycles; reset asserted
//     mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, state encodings and the control-word type for the multicycle MIPS control unit.
package mips_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the current control state into the datapath control word.
module mips_ctrl_decode
  import mips_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_e          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC and IR update only on the cycle the fetch actually completes
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMMSH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_supported(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic, control-word outputs.
// Optional memory wait handshake (mem_ready port) is enabled by defining MIPS_MEM_WAIT_EN.
//
// state    | meaning
// S_RESET  | post-reset idle, all controls low
// S_FETCH  | read instruction, PC += 4
// S_DECODE | read registers, branch target to ALUOut
// S_MEMADR | lw/sw address compute
// S_MEMRD  | lw data read
// S_MEMWB  | lw register writeback
// S_MEMWR  | sw data write
// S_REXEC  | R-type ALU operation
// S_RWB    | R-type register writeback
// S_BEQ    | branch compare / conditional PC load
// S_JUMP   | jump PC load
// S_ADDIEX | addi ALU operation
// S_ADDIWB | addi register writeback
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
`ifdef MIPS_MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_ready_w;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_ready_w = mem_ready;
`else
  assign mem_ready_w = 1'b1;
`endif

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready_w ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready_w ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_w ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  mips_ctrl_decode #(.OP_W(OP_W)) u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready_w),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control; compares the full control word every cycle.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
`ifdef MIPS_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [16:0] obs;

  int total = 0;
  int bad = 0;

  // word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal_op
  localparam logic [16:0] W_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] W_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] W_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] W_ILLEGAL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] W_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] W_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] W_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_REXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] W_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] W_BEQ     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] W_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] W_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
`ifdef MIPS_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op)
  );

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== W_ZERO) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%h want=%h", i, obs, W_ZERO);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, W_ZERO);
    end
    @(negedge clk);
    #1;
    total++;
    if (obs !== W_FETCH) begin
      bad++;
      $display("FAIL reset_to_fetch got=%h want=%h", obs, W_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [16:0] exp [6];
    exp = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_FETCH};
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [16:0] exp [5];
    exp = '{W_FETCH, W_DECODE, W_REXEC, W_RWB, W_FETCH};
    opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL rtype cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    logic [16:0] exp [7];
    logic [5:0]  ops [7];
    exp = '{W_FETCH, W_DECODE, W_BEQ, W_FETCH, W_DECODE, W_JUMP, W_FETCH};
    ops = '{6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL beq_j cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp [3];
    exp = '{W_FETCH, W_ILLEGAL, W_FETCH};
    opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL illegal cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      if (i < 2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [12];
    logic [5:0]  ops [12];
    exp = '{W_FETCH, W_DECODE, W_MEMADR, W_ADDIWB,
            W_FETCH, W_DECODE, W_MEMADR, W_MEMWR,
            W_FETCH, W_DECODE, W_JUMP, W_FETCH};
    ops = '{6'h08, 6'h08, 6'h08, 6'h08,
            6'h2B, 6'h2B, 6'h2B, 6'h2B,
            6'h02, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 12; i++) begin
      opcode = ops[i];
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      if (i < 11) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_instr();
    opcode = 6'h23;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (obs !== W_MEMRD) begin
      bad++;
      $display("FAIL abort_pre got=%h want=%h", obs, W_MEMRD);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL abort_async got=%h want=%h", obs, W_ZERO);
    end
    @(negedge clk);
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL abort_hold got=%h want=%h", obs, W_ZERO);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (obs !== W_FETCH) begin
      bad++;
      $display("FAIL abort_refetch got=%h want=%h", obs, W_FETCH);
    end
  endtask

`ifdef MIPS_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [16:0] exp [10];
    logic        rdy [10];
    // two-cycle fetch stall, then sw whose write is stalled for 4 cycles
    exp = '{W_FSTALL, W_FSTALL, W_FETCH, W_DECODE, W_MEMADR,
            W_MEMWR, W_MEMWR, W_MEMWR, W_MEMWR, W_MEMWR};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 6'h2B;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL memwait cyc%0d got=%h want=%h", i, obs, exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== W_FETCH) begin
      bad++;
      $display("FAIL memwait_done got=%h want=%h", obs, W_FETCH);
    end
    // reach MEMWR again and reset while stalled
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (obs !== W_MEMWR) begin
      bad++;
      $display("FAIL stall_pre got=%h want=%h", obs, W_MEMWR);
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL stall_reset got=%h want=%h", obs, W_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (obs !== W_FETCH) begin
      bad++;
      $display("FAIL stall_refetch got=%h want=%h", obs, W_FETCH);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid_instr();
`ifdef MIPS_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
